gate_array_pipe: RTL and testbench



---
 rtl/gate_array_pkg.sv | 20 ++
 rtl/gate_array_alu.sv | 37 +++
 rtl/gate_array_pipe.sv | 107 ++++++++++
 tb/tb_gate_array_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_array_pkg.sv
// Shared op encodings and output-buffer occupancy states for the gate array pipe.
// Optional feature macro used by this block: GATE_ARRAY_REDUCE_EN.
package gate_array_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/gate_array_alu.sv
// Combinational WIDTH-bit 2-input logic op decode; reduction {^y,|y,&y} when GATE_ARRAY_REDUCE_EN.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
module gate_array_alu
  import gate_array_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       red
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_NOTA: y = ~a;
      default: y = '0;
    endcase
  end

`ifdef GATE_ARRAY_REDUCE_EN
  assign red = {^y, |y, &y};
`else
  // Constant zero lets the downstream reduction registers fold away.
  assign red = 3'b000;
`endif

endmodule

// File: rtl/gate_array_pipe.sv
// Registered bitwise logic unit with valid/ready handshakes and a 2-entry (main+skid) output buffer.
// Latency: 1 cycle accept-to-out_valid; 1 beat/cycle. Backpressure: in_ready drops only when both entries are full.
// Optional feature: GATE_ARRAY_REDUCE_EN carries {^y,|y,&y} with each buffered result on out_red.
module gate_array_pipe
  import gate_array_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_red,
  output logic [CNT_W-1:0] txn_cnt
);

  occ_t             state, state_nxt;
  logic             accept, pop;
  logic [WIDTH-1:0] alu_y;
  logic [2:0]       alu_red;
  logic [WIDTH-1:0] main_y, skid_y;
  logic [2:0]       main_red, skid_red;
  logic [CNT_W-1:0] cnt;

  gate_array_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (in_a),
    .b   (in_b),
    .op  (in_op),
    .y   (alu_y),
    .red (alu_red)
  );

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !pop)      state_nxt = FULL;
        else if (pop && !accept) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs decode registered state only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_y   <= '0;
      main_red <= '0;
      skid_y   <= '0;
      skid_red <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_y   <= alu_y;
          main_red <= alu_red;
        end
        ONE: begin
          // Accept while main is still held: park the newer result in skid.
          if (accept && !pop) begin
            skid_y   <= alu_y;
            skid_red <= alu_red;
          end else if (accept && pop) begin
            main_y   <= alu_y;
            main_red <= alu_red;
          end
        end
        FULL: if (pop) begin
          main_y   <= skid_y;
          main_red <= skid_red;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (pop) cnt <= cnt + CNT_W'(1);
  end

  assign out_y   = main_y;
  assign out_red = main_red;
  assign txn_cnt = cnt;

endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed-vector bench for gate_array_pipe (WIDTH=8, CNT_W=4 so counter wrap is reachable).
module tb_gate_array_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [2:0] out_red;
  logic [3:0] txn_cnt;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_cnt;

  gate_array_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_red   (out_red),
    .txn_cnt   (txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] red_of(input logic [7:0] y);
`ifdef GATE_ARRAY_REDUCE_EN
    return {^y, |y, &y};
`else
    return 3'b000;
`endif
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL reset_out_y got=%h exp=00", out_y); end
    checks++; if (out_red !== 3'b000) begin failures++; $display("FAIL reset_out_red got=%b exp=000", out_red); end
    checks++; if (txn_cnt !== 4'd0) begin failures++; $display("FAIL reset_txn_cnt got=%0d exp=0", txn_cnt); end
    exp_cnt = 4'd0;
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_y [8];
    exp_y = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'h0F};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hF0, 8'hCC, 3'(i));
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ops_in_ready op=%0d got=%b exp=1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_y !== exp_y[i]) begin
        failures++; $display("FAIL ops_out_y op=%0d got=%b/%h exp=1/%h", i, out_valid, out_y, exp_y[i]);
      end
      checks++; if (out_red !== red_of(exp_y[i])) begin
        failures++; $display("FAIL ops_out_red op=%0d got=%b exp=%b", i, out_red, red_of(exp_y[i]));
      end
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    exp_cnt = exp_cnt + 4'd8;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ops_drain_valid got=%b exp=0", out_valid); end
    checks++; if (txn_cnt !== exp_cnt) begin failures++; $display("FAIL ops_txn_cnt got=%0d exp=%0d", txn_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 3'b001);
    tick();
    drive(1'b1, 8'hF0, 8'h0F, 3'b010);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
    checks++; if (out_y !== 8'h33) begin failures++; $display("FAIL bp_head got=%h exp=33", out_y); end
    drive(1'b1, 8'hAA, 8'h0F, 3'b000);
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h33) begin
      failures++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/33", in_ready, out_valid, out_y);
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_y !== 8'hFF || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_second got=%h/%b exp=ff/1", out_y, in_ready);
    end
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    checks++; if (out_y !== 8'h0A || out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_third got=%h/%b exp=0a/1", out_y, out_valid);
    end
    tick();
    exp_cnt = exp_cnt + 4'd3;
    checks++; if (out_valid !== 1'b0 || txn_cnt !== exp_cnt) begin
      failures++; $display("FAIL bp_drain got=%b/%0d exp=0/%0d", out_valid, txn_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 8'h00, 8'h5A, 3'b010);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 8'(i), 8'h5A, 3'b010);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_y !== (8'(i) ^ 8'h5A)) begin
        failures++; $display("FAIL b2b_y i=%0d got=%b/%h exp=1/%h", i, out_valid, out_y, 8'(i) ^ 8'h5A);
      end
    end
    checks++; if (dut.state !== gate_array_pkg::ONE) begin failures++; $display("FAIL b2b_state got=%0d exp=1", dut.state); end
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    exp_cnt = exp_cnt + 4'd11;
    checks++; if (out_valid !== 1'b0 || txn_cnt !== exp_cnt) begin
      failures++; $display("FAIL b2b_drain got=%b/%0d exp=0/%0d", out_valid, txn_cnt, exp_cnt);
    end
  endtask

  task automatic test_reduce();
    out_ready = 1'b1;
    drive(1'b1, 8'hFF, 8'hFF, 3'b000);
    tick();
`ifdef GATE_ARRAY_REDUCE_EN
    checks++; if (out_red !== 3'b011) begin failures++; $display("FAIL red_and got=%b exp=011", out_red); end
`else
    checks++; if (out_red !== 3'b000) begin failures++; $display("FAIL red_and got=%b exp=000", out_red); end
`endif
    drive(1'b1, 8'hFF, 8'hFF, 3'b010);
    tick();
    checks++; if (out_red !== 3'b000 || out_y !== 8'h00) begin
      failures++; $display("FAIL red_xor got=%b/%h exp=000/00", out_red, out_y);
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    exp_cnt = exp_cnt + 4'd2;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 8'h12, 8'h00, 3'b001);
    tick();
    drive(1'b1, 8'h34, 8'h00, 3'b001);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstm_full got=%b exp=0", in_ready); end
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h56, 8'h00, 3'b001);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || txn_cnt !== 4'd0 || out_y !== 8'h00) begin
      failures++; $display("FAIL rstm_state got=%b/%b/%0d/%h exp=0/1/0/00", out_valid, in_ready, txn_cnt, out_y);
    end
    drive(1'b1, 8'h9C, 8'h00, 3'b001);
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    checks++; if (out_y !== 8'h9C) begin failures++; $display("FAIL rstm_new got=%h exp=9c", out_y); end
    tick();
    checks++; if (out_valid !== 1'b0 || txn_cnt !== 4'd1) begin
      failures++; $display("FAIL rstm_after got=%b/%0d exp=0/1", out_valid, txn_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 8'h00, 3'b001);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    checks++; if (txn_cnt !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", txn_cnt); end
    tick();
    checks++; if (txn_cnt !== 4'd1) begin failures++; $display("FAIL wrap_17 got=%0d exp=1", txn_cnt); end
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_backpressure();
    test_back_to_back();
    test_reduce();
    test_reset_midstream();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
